// File: rtl/vrf_bank_array_if.sv
// Write/read bus of the banked vector register file.
// The slave modport is the register file, the master modport is issue/writeback.
interface vrf_bank_array_if #(
   parameter int NUM_BANKS = 2,
   parameter int ROWS      = 16,
   parameter int WIDTH     = 256,
   parameter int NRD       = 2
);
   localparam int ADDR_W = $clog2(NUM_BANKS * ROWS);
   localparam int BE_W   = WIDTH / 8;

   logic                    ready;
   logic                    wen;
   logic [ADDR_W-1:0]       waddr;
   logic [BE_W-1:0]         wbe;
   logic [WIDTH-1:0]        wdata;
   logic [NRD-1:0]          ren;
   logic [NRD*ADDR_W-1:0]   raddr;
   logic [NRD-1:0]          rvalid;
   logic [NRD*WIDTH-1:0]    rdata;

   modport master (
      input  ready, rvalid, rdata,
      output wen, waddr, wbe, wdata, ren, raddr
   );

   modport slave (
      output ready, rvalid, rdata,
      input  wen, waddr, wbe, wdata, ren, raddr
   );
endinterface

// File: rtl/vrf_bank_array.sv
// Banked vector register file with byte-masked writes, registered reads and a zeroing init sequencer.
// Optional macro VRF_WR_BYPASS_EN: a same-cycle read of the written address returns the merged row.
module vrf_bank_array #(
   parameter int NUM_BANKS = 2,
   parameter int ROWS      = 16,
   parameter int WIDTH     = 256,
   parameter int NRD       = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   vrf_bank_array_if.slave   bus
);
   localparam int ADDR_W = $clog2(NUM_BANKS * ROWS);
   localparam int BE_W   = WIDTH / 8;
   localparam int LOG_B  = $clog2(NUM_BANKS);
   localparam int BIDX_W = (LOG_B > 0) ? LOG_B : 1;
   localparam int ROW_W  = $clog2(ROWS);

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                 state_r;
   logic [ROW_W-1:0]       init_ptr_r;
   logic                   ready_r;
   logic [NRD-1:0]         rvalid_r;
   logic [NRD*WIDTH-1:0]   rdata_r;
   logic [WIDTH-1:0]       mem_r [NUM_BANKS][ROWS];

   logic                   run_s;
   logic [BIDX_W-1:0]      wr_bank_s;
   logic [ROW_W-1:0]       wr_row_s;
   logic [ADDR_W-1:0]      rd_addr_s [NRD];
   logic [WIDTH-1:0]       rd_row_s  [NRD];

   // Low address bits select the bank so consecutive registers alternate banks.
   function automatic logic [BIDX_W-1:0] bank_of(input logic [ADDR_W-1:0] a);
      if (NUM_BANKS > 1) begin
         return a[BIDX_W-1:0];
      end else begin
         return '0;
      end
   endfunction

   function automatic logic [ROW_W-1:0] row_of(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: ROW_W];
   endfunction

   function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] old_row,
                                                    input logic [WIDTH-1:0] new_row,
                                                    input logic [BE_W-1:0]  be);
      logic [WIDTH-1:0] res;
      for (int i = 0; i < BE_W; i++) begin
         res[8*i +: 8] = be[i] ? new_row[8*i +: 8] : old_row[8*i +: 8];
      end
      return res;
   endfunction

   // Write-side decode and run qualifier.
   always_comb begin
      run_s     = (state_r == ST_RUN);
      wr_bank_s = bank_of(bus.waddr);
      wr_row_s  = row_of(bus.waddr);
   end

   // Init sequencer: sweeps one row of every bank per cycle, then parks in RUN.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= ST_INIT;
         init_ptr_r <= '0;
         ready_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (init_ptr_r == ROW_W'(ROWS - 1)) begin
                  state_r <= ST_RUN;
                  ready_r <= 1'b1;
               end else begin
                  init_ptr_r <= init_ptr_r + ROW_W'(1);
               end
            end
            ST_RUN: begin
               ready_r <= 1'b1;
            end
            default: begin
               state_r    <= ST_INIT;
               init_ptr_r <= '0;
               ready_r    <= 1'b0;
            end
         endcase
      end
   end

   // Storage: init clears or byte-masked writes; the reset edge itself never modifies rows.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_r == ST_INIT) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
               mem_r[b][init_ptr_r] <= '0;
            end
         end else if (bus.wen) begin
            for (int i = 0; i < BE_W; i++) begin
               if (bus.wbe[i]) begin
                  mem_r[wr_bank_s][wr_row_s][8*i +: 8] <= bus.wdata[8*i +: 8];
               end
            end
         end
      end
   end

   // Per-port row fetch, optionally forwarding the same-cycle write.
   always_comb begin
      for (int p = 0; p < NRD; p++) begin
         rd_addr_s[p] = bus.raddr[p*ADDR_W +: ADDR_W];
`ifdef VRF_WR_BYPASS_EN
         rd_row_s[p] = (run_s && bus.wen && (bus.waddr == rd_addr_s[p]))
                     ? merge_bytes(mem_r[bank_of(rd_addr_s[p])][row_of(rd_addr_s[p])], bus.wdata, bus.wbe)
                     : mem_r[bank_of(rd_addr_s[p])][row_of(rd_addr_s[p])];
`else
         rd_row_s[p] = mem_r[bank_of(rd_addr_s[p])][row_of(rd_addr_s[p])];
`endif
      end
   end

   // Registered read outputs; rdata holds when a port is idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_r <= '0;
         rdata_r  <= '0;
      end else if (run_s) begin
         for (int p = 0; p < NRD; p++) begin
            rvalid_r[p] <= bus.ren[p];
            if (bus.ren[p]) begin
               rdata_r[p*WIDTH +: WIDTH] <= rd_row_s[p];
            end
         end
      end else begin
         rvalid_r <= '0;
      end
   end

   assign bus.ready  = ready_r;
   assign bus.rvalid = rvalid_r;
   assign bus.rdata  = rdata_r;

endmodule

// File: doc/vrf_bank_array.md
Name: vrf_bank_array

Overview:
- Parametrised successor to the single-bank vector register file.
- Holds NUM_BANKS x ROWS vector registers of WIDTH bits, with the register address interleaved across banks.
- Adds byte-masked writes, registered reads with valid outputs, and a self-clearing init sequencer that zeroes every row after reset.
- Sits between vector issue (read operands) and vector writeback.

Parameters:
- NUM_BANKS, 2, number of banks; power of two, >=1.
- ROWS, 16, rows per bank; power of two, >=2.
- WIDTH, 256, bits per row; multiple of 8.
- NRD, 2, number of read ports; 1..4.
- ADDR_W, $clog2(NUM_BANKS*ROWS), register address width; derived, not overridden.
- BE_W, WIDTH/8, byte-enable width; derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- ready  out  1  high once init clear is complete.
- wen  in  1  write request.
- waddr  in  ADDR_W  write register address.
- wbe  in  BE_W  byte enable; bit i covers wdata[8i+7:8i].
- wdata  in  WIDTH  write data.
- ren  in  NRD  per-port read request.
- raddr  in  NRD*ADDR_W  per-port read address; port p uses slice p.
- rvalid  out  NRD  per-port read-data valid.
- rdata  out  NRD*WIDTH  per-port read data.

Behaviour:
- Address map: bank = addr[log2(NUM_BANKS)-1:0]; row = addr[ADDR_W-1:log2(NUM_BANKS)]. With NUM_BANKS=1 the bank field is empty and row = addr.
- Reset (rst_n=0 at a clk edge):
  - FSM enters INIT and init_ptr is set to 0.
  - ready, rvalid and rdata are all cleared to 0.
  - Array contents are not touched by reset itself.
- FSM states:
  - INIT: each cycle, row init_ptr of every bank is written to all-zero, then init_ptr increments. When init_ptr==ROWS-1 the FSM moves to RUN at the next edge. INIT lasts exactly ROWS cycles after rst_n is released.
  - RUN: ready=1. The FSM stays in RUN until the next reset.
- During INIT:
  - wen and ren are ignored.
  - rvalid stays 0.
  - No external write lands.
- Reset asserted mid-INIT or mid-RUN: the sequence restarts from init_ptr=0 and all rows are re-cleared.
- Write (RUN, wen=1): at the edge, each byte i of the row at waddr with wbe[i]=1 takes wdata byte i. Bytes with wbe[i]=0 keep their value. wbe=0 is a no-op.
- Read (RUN, ren[p]=1):
  - Latency is 1 cycle.
  - rvalid[p]=1 and rdata[p] = row contents in the cycle after the request.
  - When ren[p]=0, rvalid[p]=0 next cycle and rdata[p] holds its previous value.
- Port independence:
  - All NRD ports may read any address, including the same address or bank, in the same cycle.
  - There are no conflicts and no stalls.
- Simultaneous write and read to the same address in one cycle: see Optional Feature.
- Writes to different addresses never affect read data of the same cycle.
- Addresses are always in range by construction; there is no error path.

Optional Feature:
- Macro: VRF_WR_BYPASS_EN.
- Defined: a read of address A in the same cycle as a write to A returns the post-write merged row (wbe-selected bytes from wdata, other bytes from the array).
- Undefined: such a read returns the pre-write row contents; the new data is visible from the next cycle's read onward.
- With or without the macro, read latency is unchanged.

Test Plan:
- Init check: deassert rst_n, count cycles.
  - ready rises exactly 16 cycles later (ROWS=16).
  - Reading all 32 addresses then returns 0 with rvalid=1 one cycle after each ren.
- Byte mask:
  - Write addr 5, wdata all 0xAA, wbe all-ones; then write addr 5, wdata all 0x55, wbe=0x0000_000F.
  - Read addr 5 returns low 4 bytes 0x55 and the remaining 28 bytes 0xAA.
- Interleave: write 0x1 to addr 2 and 0x2 to addr 3 (banks 0 and 1, row 1).
  - Port0 reads addr 2 and port1 reads addr 3 in the same cycle.
  - Next cycle: rdata0=0x1, rdata1=0x2, rvalid=2'b11.
- Same-cycle RAW: addr 7 holds 0x10; in one cycle, write 0x20 (full wbe) to addr 7 and read addr 7.
  - Result is 0x20 with VRF_WR_BYPASS_EN, 0x10 without.
  - The following read returns 0x20 in both builds.
- Reset mid-operation:
  - Fill addr 9 with 0xFF; pulse rst_n low for 1 cycle during RUN.
  - ready drops, ren during INIT gives rvalid=0, and after 16 cycles a read of addr 9 returns 0.
- Hold behaviour: read addr 4 (=0x33) and then drop ren.
  - rvalid goes 0 and rdata stays 0x33 until the next read.
